// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART transmit state encoding and default bit timing
package uart_tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  localparam int UART_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; full/empty derived from the occupancy count
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter with a registered, glitch-free io_tx
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        io_tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  uart_tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d, nb;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, pop, full, empty, last;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_valid && tx_ready), .din(tx_data),
    .pop(pop), .dout(head), .count(fifo_count), .full(full), .empty(empty)
  );
  assign tx_ready = !full;
  assign tx_busy = state_q != IDLE || !empty;
  assign io_tx = tx_q;
  assign last = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign nb = bit_q + 3'd1;
  // tx_d is the line level of the next cycle, so io_tx comes straight from a flop
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d = 1'b0;
        end
      end
      START: if (last) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = DATA;
        tx_d = shift_q[0];
      end
      DATA: if (last) begin
        cnt_d = '0;
        state_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_q == 3'd7 ? bit_q : nb;
        tx_d = bit_q == 3'd7 ? 1'b1 : shift_q[nb];
      end
      STOP: if (last) begin
        cnt_d = '0;
        pop = !empty;
        state_d = empty ? IDLE : START;
        shift_d = empty ? shift_q : head;
        tx_d = empty;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; stimulus queues expected bytes, a line monitor decodes frames
module tb_uart_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 0, reset_n = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, io_tx, tx_busy;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_bad = 0, cyc = 0, nframes = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  logic in_frame = 0;
  int nsamp = 0;
  logic [39:0] samp;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .io_tx(io_tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame();
    logic [7:0] b;
    int hold_bad = 0;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < CPB; j++)
        if (samp[CPB*k+j] !== samp[CPB*k]) hold_bad++;
    for (int i = 0; i < 8; i++) b[i] = samp[CPB*(i+1)];
    chk("start_bit", int'(samp[3:0]), 0);
    chk("stop_bit", int'(samp[39:36]), 15);
    chk("bit_hold", hold_bad, 0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_frame: got byte %0d expected no frame", b);
    end else chk("byte", int'(b), int'(exp_q.pop_front()));
    nframes++;
  endtask

  // Monitor: each frame is 40 negedge samples beginning at the first low sample
  initial forever begin
    @(negedge clk);
    if (!reset_n) in_frame = 0;
    else if (!in_frame) begin
      if (io_tx === 1'b0) begin
        in_frame = 1;
        samp[0] = 1'b0;
        nsamp = 1;
        start_q.push_back(cyc);
      end
    end else begin
      samp[nsamp] = io_tx;
      nsamp++;
      if (nsamp == 10 * CPB) begin
        in_frame = 0;
        check_frame();
      end
    end
  end

  task automatic push1(input logic [7:0] b, output int acc);
    tx_data = b;
    tx_valid = 1;
    chk("ready_on_push", int'(tx_ready), 1);
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 0;
    acc = cyc;
  endtask

  task automatic wait_idle(input int budget, output int endc);
    logic done = 0;
    endc = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!tx_busy) begin done = 1; endc = cyc; end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", budget);
    end
  endtask

  initial begin
    int acc, acc2, e, s0, base, lows;
    repeat (3) @(negedge clk);
    chk("rst_io_tx", int'(io_tx), 1);
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_count", int'(fifo_count), 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    s0 = start_q.size();
    push1(8'h55, acc);
    chk("single_busy", int'(tx_busy), 1);
    wait_idle(100, e);
    chk("single_len", e - acc - 1, 40);
    chk("single_frames", start_q.size() - s0, 1);
    if (start_q.size() > s0) chk("single_latency", start_q[s0] - acc, 1);
    chk("single_idle_tx", int'(io_tx), 1);

    s0 = start_q.size();
    push1(8'hA5, acc);
    push1(8'h3C, acc2);
    wait_idle(150, e);
    chk("b2b_len", e - acc - 1, 80);
    chk("b2b_frames", start_q.size() - s0, 2);
    if (start_q.size() >= s0 + 2) begin
      chk("b2b_latency", start_q[s0] - acc, 1);
      chk("b2b_gap", start_q[s0+1] - start_q[s0], 40);
    end

    base = cyc;
    for (int i = 0; i < 8; i++) begin
      tx_data = 8'(i + 1);
      tx_valid = 1;
      chk("ovf_ready", int'(tx_ready), i < 5 ? 1 : 0);
      if (i == 5) chk("ovf_count_full", int'(fifo_count), 4);
      if (i < 5) exp_q.push_back(8'(i + 1));
      @(negedge clk);
    end
    tx_valid = 0;
    repeat (33) @(negedge clk);
    chk("ovf_ready_hold", int'(tx_ready), 0);
    chk("ovf_count_hold", int'(fifo_count), 4);
    @(negedge clk);
    chk("ovf_ready_back", int'(tx_ready), 1);
    chk("ovf_count_back", int'(fifo_count), 3);
    wait_idle(300, e);
    chk("ovf_len", e - base, 202);

    push1(8'hFF, acc);
    push1(8'h11, acc);
    push1(8'h22, acc);
    repeat (16) @(negedge clk);
    chk("mid_count", int'(fifo_count), 2);
    #1 reset_n = 0;
    exp_q.delete();
    #1;
    chk("mid_rst_tx", int'(io_tx), 1);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_busy", int'(tx_busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (io_tx !== 1'b1) lows++;
    end
    chk("post_rst_low_cycles", lows, 0);
    chk("post_rst_count", int'(fifo_count), 0);

    push1(8'h00, acc);
    push1(8'hFF, acc);
    wait_idle(150, e);

    push1(8'h00, acc);
    repeat (8) @(negedge clk);
    chk("pre_async_low", int'(io_tx), 0);
    #1 reset_n = 0;
    exp_q.delete();
    #1;
    chk("async_rst_tx", int'(io_tx), 1);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    chk("frames_total", nframes, 10);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
